// File: rtl/dmd_scan_capture_if.sv
// ---------------------------------------------------------------------------
// dmd_scan_capture_if
// Groups the dot-matrix scan pins and the frame readback/handshake signals of
// dmd_scan_capture.
//   DMD_CLK, DMD_CLR, dmd_seg[3:0], dmd_column[15:0] : scan pins (driver -> capture)
//   rd_addr[3:0] / rd_data[15:0]                      : visible-bank readback
//   frame_valid / frame_ack                           : completed-frame handshake
//   frame_count[FRAME_CNT_W-1:0]                      : completed frames (wraps)
//   overrun, seq_err / err_clr                        : sticky error flags and clear
// master: the side driving scan pins and reading frames; slave: dmd_scan_capture.
// ---------------------------------------------------------------------------
interface dmd_scan_capture_if #(
    parameter int unsigned FRAME_CNT_W = 8
);
    logic                   DMD_CLK;
    logic                   DMD_CLR;
    logic [3:0]             dmd_seg;
    logic [15:0]            dmd_column;
    logic [3:0]             rd_addr;
    logic [15:0]            rd_data;
    logic                   frame_valid;
    logic                   frame_ack;
    logic [FRAME_CNT_W-1:0] frame_count;
    logic                   overrun;
    logic                   seq_err;
    logic                   err_clr;

    modport master (
        output DMD_CLK, DMD_CLR, dmd_seg, dmd_column, rd_addr, frame_ack, err_clr,
        input  rd_data, frame_valid, frame_count, overrun, seq_err
    );

    modport slave (
        input  DMD_CLK, DMD_CLR, dmd_seg, dmd_column, rd_addr, frame_ack, err_clr,
        output rd_data, frame_valid, frame_count, overrun, seq_err
    );
endinterface

// File: rtl/dmd_scan_capture.sv
// ---------------------------------------------------------------------------
// dmd_scan_capture
// Receive-side model of the dot-matrix scan interface. Rebuilds the 16-column
// frame from the DMD_CLK/DMD_CLR/dmd_seg/dmd_column pins into a shadow bank and
// swaps it into the visible bank when column 15 lands in order.
// Ports:
//   CLK    : system clock, rising edge
//   RESET  : asynchronous active-low reset
//   bus    : dmd_scan_capture_if.slave (scan pins, readback, handshake, errors)
// Build option:
//   DMD_CAPTURE_SYNC_EN defined   -> scan pins pass a 2-flop synchronizer (S=2)
//   DMD_CAPTURE_SYNC_EN undefined -> scan pins pass a single register (S=1)
// ---------------------------------------------------------------------------
module dmd_scan_capture #(
    parameter int unsigned FRAME_CNT_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    dmd_scan_capture_if.slave bus
);

`ifdef DMD_CAPTURE_SYNC_EN
    localparam int unsigned S = 2;
`else
    localparam int unsigned S = 1;
`endif
    localparam int unsigned SEG_W = 4;
    localparam int unsigned COL_W = 16;
    localparam int unsigned NCOL  = 16;

    // Scan pins travel as one bundle so strobe, clear, index and data stay aligned.
    typedef struct packed {
        logic             clk;
        logic             clr;
        logic [SEG_W-1:0] seg;
        logic [COL_W-1:0] col;
    } scan_t;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        FILL  = 2'd1,
        BLANK = 2'd2
    } state_t;

    scan_t                  w_in;
    scan_t                  w_stg;
    scan_t                  r_stage [S];
    logic                   r_clk_hist;
    logic                   w_stb;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SEG_W-1:0]       r_expect;
    logic [SEG_W-1:0]       w_expect_nxt;
    logic                   w_wr_en;
    logic                   w_swap;
    logic                   w_seq_evt;

    logic [COL_W-1:0]       r_bank [2][NCOL];
    logic                   r_vis_sel;
    logic                   w_shadow_sel;

    logic [COL_W-1:0]       r_rd_data;
    logic                   r_frame_valid;
    logic [FRAME_CNT_W-1:0] r_frame_count;
    logic                   r_overrun;
    logic                   r_seq_err;

    assign w_in.clk = bus.DMD_CLK;
    assign w_in.clr = bus.DMD_CLR;
    assign w_in.seg = bus.dmd_seg;
    assign w_in.col = bus.dmd_column;

    // Input stage chain (S deep).
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < int'(S); i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= w_in;
            for (int i = 1; i < int'(S); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign w_stg = r_stage[S-1];

    // Rising-edge detect on the staged column strobe.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_clk_hist <= 1'b0;
        end else begin
            r_clk_hist <= w_stg.clk;
        end
    end

    assign w_stb = w_stg.clk & ~r_clk_hist;

    // FSM state register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state  <= HUNT;
            r_expect <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_expect <= w_expect_nxt;
        end
    end

    // Next state: a partial frame is dropped implicitly, since only a strictly
    // ordered 0..15 run reaches the swap and it rewrites every shadow column.
    always_comb begin
        w_state_nxt  = r_state;
        w_expect_nxt = r_expect;
        w_wr_en      = 1'b0;
        w_swap       = 1'b0;
        w_seq_evt    = 1'b0;
        if (w_stg.clr) begin
            w_state_nxt  = BLANK;
            w_expect_nxt = '0;
        end else begin
            case (r_state)
                HUNT: begin
                    if (w_stb) begin
                        if (w_stg.seg == '0) begin
                            w_wr_en      = 1'b1;
                            w_expect_nxt = SEG_W'(1);
                            w_state_nxt  = FILL;
                        end else begin
                            w_seq_evt = 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (w_stb) begin
                        if (w_stg.seg == r_expect) begin
                            w_wr_en      = 1'b1;
                            w_expect_nxt = SEG_W'(r_expect + SEG_W'(1));
                            if (w_stg.seg == SEG_W'(NCOL - 1)) begin
                                w_swap      = 1'b1;
                                w_state_nxt = HUNT;
                            end
                        end else begin
                            w_seq_evt = 1'b1;
                            if (w_stg.seg == '0) begin
                                w_wr_en      = 1'b1;
                                w_expect_nxt = SEG_W'(1);
                            end else begin
                                w_expect_nxt = '0;
                                w_state_nxt  = HUNT;
                            end
                        end
                    end
                end
                BLANK: begin
                    w_expect_nxt = '0;
                    w_state_nxt  = HUNT;
                end
                default: begin
                    w_expect_nxt = '0;
                    w_state_nxt  = HUNT;
                end
            endcase
        end
    end

    assign w_shadow_sel = ~r_vis_sel;

    // Banks: swapping flips the visible pointer on the same edge column 15 lands.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < int'(NCOL); c++) begin
                    r_bank[b][c] <= '0;
                end
            end
            r_vis_sel <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_bank[w_shadow_sel][w_stg.seg] <= w_stg.col;
            end
            if (w_swap) begin
                r_vis_sel <= w_shadow_sel;
            end
        end
    end

    // Readback, handshake and sticky error flags; a new event beats a clear.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rd_data     <= '0;
            r_frame_valid <= 1'b0;
            r_frame_count <= '0;
            r_overrun     <= 1'b0;
            r_seq_err     <= 1'b0;
        end else begin
            r_rd_data <= r_bank[r_vis_sel][bus.rd_addr];

            if (w_swap) begin
                r_frame_valid <= 1'b1;
                r_frame_count <= FRAME_CNT_W'(r_frame_count + FRAME_CNT_W'(1));
            end else if (bus.frame_ack) begin
                r_frame_valid <= 1'b0;
            end

            if (w_swap && r_frame_valid && !bus.frame_ack) begin
                r_overrun <= 1'b1;
            end else if (bus.err_clr) begin
                r_overrun <= 1'b0;
            end

            if (w_seq_evt) begin
                r_seq_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_seq_err <= 1'b0;
            end
        end
    end

    assign bus.rd_data     = r_rd_data;
    assign bus.frame_valid = r_frame_valid;
    assign bus.frame_count = r_frame_count;
    assign bus.overrun     = r_overrun;
    assign bus.seq_err     = r_seq_err;

endmodule
